// File: rtl/raizing_snd_pkg.sv
// Shared types and constants for the Raizing sound PCM path.
package raizing_snd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } pcm_state_t;

   // Byte returned for out-of-range reads and timeouts.
   localparam logic [7:0] PCM_FILL_BYTE = 8'h00;

   localparam int CNT_W = 16;

endpackage

// File: rtl/raizing_pcm_router_if.sv
// Requester and bank-side bus of the PCM router; master = PCM chip / SDRAM side, slave = router.
interface raizing_pcm_router_if #(
   parameter int NBANKS  = 3,
   parameter int BANK_AW = 22,
   parameter int ADDR_W  = 24
);
   logic                      REQ_RD;
   logic [ADDR_W-1:0]         REQ_ADDR;
   logic [7:0]                RSP_DOUT;
   logic                      RSP_VALID;
   logic [NBANKS-1:0]         BANK_CS;
   logic [NBANKS*BANK_AW-1:0] BANK_ADDR;
   logic [NBANKS-1:0]         BANK_OK;
   logic [NBANKS*8-1:0]       BANK_DOUT;
   logic                      ERR_TIMEOUT;

   modport master (
      output REQ_RD, REQ_ADDR, BANK_OK, BANK_DOUT,
      input  RSP_DOUT, RSP_VALID, BANK_CS, BANK_ADDR, ERR_TIMEOUT
   );

   modport slave (
      input  REQ_RD, REQ_ADDR, BANK_OK, BANK_DOUT,
      output RSP_DOUT, RSP_VALID, BANK_CS, BANK_ADDR, ERR_TIMEOUT
   );
endinterface

// File: rtl/raizing_pcm_tagcache.sv
// One-entry last-byte cache: full-address tag, data byte, valid bit.
module raizing_pcm_tagcache
   import raizing_snd_pkg::*;
#(
   parameter int ADDR_W = 24
) (
   input  logic              CLK96,
   input  logic              RESET96_N,
   input  logic [ADDR_W-1:0] lookup_addr,
   output logic              hit,
   output logic [7:0]        hit_data,
   input  logic              fill_en,
   input  logic [ADDR_W-1:0] fill_addr,
   input  logic [7:0]        fill_data,
   input  logic              inval
);
   logic              valid_reg;
   logic [ADDR_W-1:0] tag_reg;
   logic [7:0]        data_reg;

   always_ff @(posedge CLK96) begin
      if (!RESET96_N) begin
         valid_reg <= 1'b0;
         tag_reg   <= '0;
         data_reg  <= PCM_FILL_BYTE;
      end else if (inval) begin
         valid_reg <= 1'b0;
      end else if (fill_en) begin
         valid_reg <= 1'b1;
         tag_reg   <= fill_addr;
         data_reg  <= fill_data;
      end
   end

   assign hit      = valid_reg && (tag_reg == lookup_addr);
   assign hit_data = data_reg;
endmodule

// File: rtl/raizing_pcm_router.sv
// Raizing PCM read router: steers byte reads to one of NBANKS SDRAM banks with a per-read timeout.
// Defining RAIZING_PCM_CACHE_EN adds a one-entry last-byte cache (raizing_pcm_tagcache).
module raizing_pcm_router
   import raizing_snd_pkg::*;
#(
   parameter int NBANKS  = 3,
   parameter int BANK_AW = 22,
   parameter int ADDR_W  = 24,
   parameter int TIMEOUT = 255
) (
   input  logic                 CLK96,
   input  logic                 RESET96_N,
   raizing_pcm_router_if.slave  bus
);
   localparam int BIDX_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;

   pcm_state_t        state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg, addr_next;
   logic [BIDX_W-1:0] bank_reg, bank_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [NBANKS-1:0] cs_reg, cs_next;
   logic [7:0]        dout_reg, dout_next;
   logic              valid_reg, valid_next;
   logic              err_reg, err_next;

   logic [ADDR_W-1:0] req_sel;
   logic              req_in_range;
   logic [BIDX_W-1:0] req_bank;
   wire  [NBANKS-1:0] req_onehot;
   logic [NBANKS-1:0] slice_load;
   logic              bank_ok;
   logic [7:0]        bank_byte;
   logic [CNT_W:0]    cnt_inc;
   logic              wait_expired;
   logic              cache_hit;
   logic [7:0]        cache_data;
   logic              fill_en;
   logic              inval;
   wire  [NBANKS*BANK_AW-1:0] bank_addr_flat;

   // Bank field is taken zero-extended so a 1-bank build needs no zero-width slice.
   assign req_sel      = bus.REQ_ADDR >> BANK_AW;
   assign req_in_range = req_sel < ADDR_W'(NBANKS);
   assign req_bank     = req_sel[BIDX_W-1:0];

   assign bank_ok      = bus.BANK_OK[bank_reg];
   assign bank_byte    = bus.BANK_DOUT[8*bank_reg +: 8];
   assign cnt_inc      = {1'b0, cnt_reg} + (CNT_W+1)'(1);
   assign wait_expired = cnt_inc >= (CNT_W+1)'(TIMEOUT);

   genvar gi;
   generate
      for (gi = 0; gi < NBANKS; gi++) begin : g_bank
         logic [BANK_AW-1:0] addr_slice_reg;

         assign req_onehot[gi] = req_in_range && (req_sel == ADDR_W'(gi));

         always_ff @(posedge CLK96) begin
            if (!RESET96_N) begin
               addr_slice_reg <= '0;
            end else if (slice_load[gi]) begin
               addr_slice_reg <= bus.REQ_ADDR[BANK_AW-1:0];
            end
         end

         assign bank_addr_flat[gi*BANK_AW +: BANK_AW] = addr_slice_reg;
      end
   endgenerate

   always_ff @(posedge CLK96) begin
      if (!RESET96_N) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         bank_reg  <= '0;
         cnt_reg   <= '0;
         cs_reg    <= '0;
         dout_reg  <= PCM_FILL_BYTE;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         addr_reg  <= addr_next;
         bank_reg  <= bank_next;
         cnt_reg   <= cnt_next;
         cs_reg    <= cs_next;
         dout_reg  <= dout_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      addr_next  = addr_reg;
      bank_next  = bank_reg;
      cnt_next   = cnt_reg;
      cs_next    = cs_reg;
      dout_next  = dout_reg;
      valid_next = 1'b0;
      err_next   = err_reg;
      slice_load = '0;
      fill_en    = 1'b0;
      inval      = 1'b0;

      case (state_reg)
         IDLE: begin
            if (bus.REQ_RD) begin
               addr_next = bus.REQ_ADDR;
               cnt_next  = '0;
               if (!req_in_range) begin
                  state_next = RESP;
                  dout_next  = PCM_FILL_BYTE;
                  valid_next = 1'b1;
               end else if (cache_hit) begin
                  state_next = RESP;
                  dout_next  = cache_data;
                  valid_next = 1'b1;
               end else begin
                  state_next = WAIT;
                  bank_next  = req_bank;
                  cs_next    = req_onehot;
                  slice_load = req_onehot;
               end
            end
         end

         WAIT: begin
            cnt_next = cnt_inc[CNT_W-1:0];
            // OK has priority over an expiring counter in the same cycle.
            if (bank_ok) begin
               state_next = RESP;
               dout_next  = bank_byte;
               valid_next = 1'b1;
               cs_next    = '0;
               cnt_next   = '0;
               fill_en    = 1'b1;
            end else if (wait_expired) begin
               state_next = RESP;
               dout_next  = PCM_FILL_BYTE;
               valid_next = 1'b1;
               cs_next    = '0;
               cnt_next   = '0;
               err_next   = 1'b1;
               inval      = 1'b1;
            end
         end

         RESP: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
            cs_next    = '0;
         end
      endcase
   end

`ifdef RAIZING_PCM_CACHE_EN
   raizing_pcm_tagcache #(
      .ADDR_W (ADDR_W)
   ) u_tagcache (
      .CLK96       (CLK96),
      .RESET96_N   (RESET96_N),
      .lookup_addr (bus.REQ_ADDR),
      .hit         (cache_hit),
      .hit_data    (cache_data),
      .fill_en     (fill_en),
      .fill_addr   (addr_reg),
      .fill_data   (bank_byte),
      .inval       (inval)
   );
`else
   logic unused_cache;
   assign cache_hit    = 1'b0;
   assign cache_data   = PCM_FILL_BYTE;
   assign unused_cache = ^{fill_en, inval, addr_reg};
`endif

   assign bus.BANK_CS     = cs_reg;
   assign bus.BANK_ADDR   = bank_addr_flat;
   assign bus.RSP_DOUT    = dout_reg;
   assign bus.RSP_VALID   = valid_reg;
   assign bus.ERR_TIMEOUT = err_reg;
endmodule

// File: tb/tb_raizing_pcm_router.sv
// Directed bench for raizing_pcm_router: default instance plus a TIMEOUT=4 instance on one clock.
module tb_raizing_pcm_router;
   import raizing_snd_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;

   raizing_pcm_router_if #(.NBANKS(3), .BANK_AW(22), .ADDR_W(24)) bus0 ();
   raizing_pcm_router_if #(.NBANKS(3), .BANK_AW(22), .ADDR_W(24)) bus1 ();

   raizing_pcm_router dut0 (
      .CLK96     (clk),
      .RESET96_N (rst_n),
      .bus       (bus0)
   );

   raizing_pcm_router #(.TIMEOUT(4)) dut1 (
      .CLK96     (clk),
      .RESET96_N (rst_n),
      .bus       (bus1)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      bus0.REQ_RD = 1'b0; bus0.REQ_ADDR = '0; bus0.BANK_OK = '0; bus0.BANK_DOUT = '0;
      bus1.REQ_RD = 1'b0; bus1.REQ_ADDR = '0; bus1.BANK_OK = '0; bus1.BANK_DOUT = '0;
      rst_n = 1'b0;
      tick();
      tick();

      // reset state
      check("rst_cs",    32'(bus0.BANK_CS), 32'h0);
      check("rst_addr0", 32'(bus0.BANK_ADDR == '0), 32'h1);
      check("rst_dout",  32'(bus0.RSP_DOUT), 32'h00);
      check("rst_valid", 32'(bus0.RSP_VALID), 32'h0);
      check("rst_err",   32'(bus0.ERR_TIMEOUT), 32'h0);
      rst_n = 1'b1;
      tick();

      // bank 1 read, OK two cycles after BANK_CS; REQ_RD dropped and REQ_ADDR scrambled in WAIT
      bus0.REQ_RD    = 1'b1;
      bus0.REQ_ADDR  = 24'h412345;
      bus0.BANK_DOUT = {8'h11, 8'hA5, 8'h22};
      tick();
      check("a_cs",     32'(bus0.BANK_CS), 32'h2);
      check("a_slice1", 32'(bus0.BANK_ADDR[43:22]), 32'h012345);
      check("a_slice0", 32'(bus0.BANK_ADDR[21:0]), 32'h0);
      check("a_valid1", 32'(bus0.RSP_VALID), 32'h0);
      bus0.REQ_RD   = 1'b0;
      bus0.REQ_ADDR = 24'h000777;
      tick();
      bus0.BANK_OK = 3'b001;
      tick();
      check("a_cs3",    32'(bus0.BANK_CS), 32'h2);
      check("a_valid3", 32'(bus0.RSP_VALID), 32'h0);
      bus0.BANK_OK = 3'b010;
      tick();
      bus0.BANK_OK = 3'b000;
      check("a_valid",  32'(bus0.RSP_VALID), 32'h1);
      check("a_dout",   32'(bus0.RSP_DOUT), 32'hA5);
      check("a_cs_off", 32'(bus0.BANK_CS), 32'h0);
      $display("txn A addr=412345 dout=%02h", bus0.RSP_DOUT);
      tick();
      check("a_pulse",  32'(bus0.RSP_VALID), 32'h0);
      check("a_hold",   32'(bus0.RSP_DOUT), 32'hA5);
      check("a_keep1",  32'(bus0.BANK_ADDR[43:22]), 32'h012345);

      // out-of-range bank 3
      bus0.REQ_RD   = 1'b1;
      bus0.REQ_ADDR = 24'hC00010;
      tick();
      bus0.REQ_RD = 1'b0;
      check("b_valid", 32'(bus0.RSP_VALID), 32'h1);
      check("b_dout",  32'(bus0.RSP_DOUT), 32'h00);
      check("b_cs",    32'(bus0.BANK_CS), 32'h0);
      check("b_err",   32'(bus0.ERR_TIMEOUT), 32'h0);
      $display("txn B addr=C00010 dout=%02h", bus0.RSP_DOUT);
      tick();
      check("b_pulse", 32'(bus0.RSP_VALID), 32'h0);

      // timeout on the TIMEOUT=4 instance
      bus1.REQ_RD   = 1'b1;
      bus1.REQ_ADDR = 24'h000200;
      tick();
      for (int k = 0; k < 4; k++) begin
         bus1.REQ_RD = 1'b0;
         check($sformatf("c_cs%0d", k),    32'(bus1.BANK_CS), 32'h1);
         check($sformatf("c_valid%0d", k), 32'(bus1.RSP_VALID), 32'h0);
         tick();
      end
      check("c_cs_off", 32'(bus1.BANK_CS), 32'h0);
      check("c_valid",  32'(bus1.RSP_VALID), 32'h1);
      check("c_dout",   32'(bus1.RSP_DOUT), 32'h00);
      check("c_err",    32'(bus1.ERR_TIMEOUT), 32'h1);
      $display("txn C addr=000200 timeout dout=%02h err=%0b", bus1.RSP_DOUT, bus1.ERR_TIMEOUT);
      tick();

      // good read after timeout: minimum latency, error stays sticky
      bus1.REQ_RD    = 1'b1;
      bus1.REQ_ADDR  = 24'h000300;
      bus1.BANK_DOUT = {8'h00, 8'h00, 8'h5A};
      tick();
      check("d_cs",     32'(bus1.BANK_CS), 32'h1);
      check("d_slice0", 32'(bus1.BANK_ADDR[21:0]), 32'h000300);
      bus1.REQ_RD  = 1'b0;
      bus1.BANK_OK = 3'b001;
      tick();
      bus1.BANK_OK = 3'b000;
      check("d_valid", 32'(bus1.RSP_VALID), 32'h1);
      check("d_dout",  32'(bus1.RSP_DOUT), 32'h5A);
      check("d_err",   32'(bus1.ERR_TIMEOUT), 32'h1);
      $display("txn D addr=000300 dout=%02h err=%0b", bus1.RSP_DOUT, bus1.ERR_TIMEOUT);
      tick();
      check("d_err2",  32'(bus1.ERR_TIMEOUT), 32'h1);

      // repeated read of 000100: cache hit when enabled, bank access otherwise
      bus0.REQ_RD    = 1'b1;
      bus0.REQ_ADDR  = 24'h000100;
      bus0.BANK_DOUT = {8'h11, 8'h22, 8'h3C};
      tick();
      check("e_cs", 32'(bus0.BANK_CS), 32'h1);
      bus0.REQ_RD  = 1'b0;
      bus0.BANK_OK = 3'b001;
      tick();
      bus0.BANK_OK = 3'b000;
      check("e_dout", 32'(bus0.RSP_DOUT), 32'h3C);
      $display("txn E1 addr=000100 dout=%02h", bus0.RSP_DOUT);
      tick();
      bus0.REQ_RD    = 1'b1;
      bus0.BANK_DOUT = {8'h11, 8'h22, 8'h77};
      tick();
      bus0.REQ_RD = 1'b0;
`ifdef RAIZING_PCM_CACHE_EN
      check("e2_valid", 32'(bus0.RSP_VALID), 32'h1);
      check("e2_dout",  32'(bus0.RSP_DOUT), 32'h3C);
      check("e2_cs",    32'(bus0.BANK_CS), 32'h0);
      $display("txn E2 addr=000100 cached dout=%02h", bus0.RSP_DOUT);
      tick();
`else
      check("e2_cs",    32'(bus0.BANK_CS), 32'h1);
      check("e2_valid", 32'(bus0.RSP_VALID), 32'h0);
      bus0.BANK_OK = 3'b001;
      tick();
      bus0.BANK_OK = 3'b000;
      check("e2_dout",  32'(bus0.RSP_DOUT), 32'h77);
      $display("txn E2 addr=000100 uncached dout=%02h", bus0.RSP_DOUT);
      tick();
`endif
      tick();

      // reset pulse during WAIT on bank 0
      bus0.REQ_RD    = 1'b1;
      bus0.REQ_ADDR  = 24'h000040;
      bus0.BANK_DOUT = {8'h11, 8'h22, 8'h99};
      tick();
      check("f_cs", 32'(bus0.BANK_CS), 32'h1);
      bus0.REQ_RD = 1'b0;
      rst_n       = 1'b0;
      tick();
      rst_n        = 1'b1;
      bus0.BANK_OK = 3'b001;
      check("f_cs0",   32'(bus0.BANK_CS), 32'h0);
      check("f_addr0", 32'(bus0.BANK_ADDR == '0), 32'h1);
      check("f_dout0", 32'(bus0.RSP_DOUT), 32'h00);
      check("f_valid", 32'(bus0.RSP_VALID), 32'h0);
      check("f_err1",  32'(bus1.ERR_TIMEOUT), 32'h0);
      tick();
      check("f_valid2", 32'(bus0.RSP_VALID), 32'h0);
      check("f_cs2",    32'(bus0.BANK_CS), 32'h0);
      tick();
      bus0.BANK_OK = 3'b000;
      check("f_valid3", 32'(bus0.RSP_VALID), 32'h0);
      $display("txn F addr=000040 dropped by reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
